// File: rtl/int_priority_encoder_if.sv
// Request/service bus between the interrupt lines, the priority encoder and the control unit.
// Optional INT_MASK_EN adds the irq_mask signal.
interface int_priority_encoder_if #(
   parameter int unsigned LINES = 8,
   parameter int unsigned ID_W  = 3
);
   logic [LINES-1:0] req;
   logic             out_ack;
`ifdef INT_MASK_EN
   logic [LINES-1:0] irq_mask;
`endif
   logic             out_valid;
   logic [ID_W-1:0]  out_id;
   logic [LINES-1:0] out_onehot;
   logic [LINES-1:0] pending;

   modport master (
`ifdef INT_MASK_EN
      output irq_mask,
`endif
      output req,
      output out_ack,
      input  out_valid,
      input  out_id,
      input  out_onehot,
      input  pending
   );

   modport slave (
`ifdef INT_MASK_EN
      input  irq_mask,
`endif
      input  req,
      input  out_ack,
      output out_valid,
      output out_id,
      output out_onehot,
      output pending
   );
endinterface

// File: rtl/int_priority_encoder.sv
// Sticky 8-to-3 interrupt priority encoder with a valid/ack presentation handshake.
// Optional INT_MASK_EN excludes masked pending lines from selection.
module int_priority_encoder #(
   parameter int unsigned LINES    = 8,
   parameter int unsigned ID_W     = 3,
   parameter bit          PRIO_MSB = 1'b1
) (
   input logic                   clk,
   input logic                   rst_n,
   int_priority_encoder_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e           state_q, state_d;
   logic [LINES-1:0] pending_q, pending_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [LINES-1:0] onehot_q, onehot_d;
   logic             valid_q, valid_d;

   logic [LINES-1:0] elig;
   logic [LINES-1:0] clr;
   logic [ID_W-1:0]  win_id;
   logic             ack;

`ifdef INT_MASK_EN
   assign elig = pending_q & ~bus.irq_mask;
`else
   assign elig = pending_q;
`endif

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      int unsigned j;
      win_id = '0;
      j      = 0;
      for (int unsigned i = 0; i < LINES; i++) begin
         j = PRIO_MSB ? i : (LINES - 1 - i);
         if (elig[j]) begin
            win_id = j[ID_W-1:0];
         end
      end
   end

   assign ack = (state_q == StPresent) && bus.out_ack;
   assign clr = ack ? onehot_q : '0;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      onehot_d  = onehot_q;
      valid_d   = valid_q;
      pending_d = (pending_q & ~clr) | bus.req;
      unique case (state_q)
         StIdle: begin
            if (elig != '0) begin
               state_d  = StPresent;
               id_d     = win_id;
               onehot_d = {{(LINES-1){1'b0}}, 1'b1} << win_id;
               valid_d  = 1'b1;
            end
         end
         StPresent: begin
            // Held regardless of new requests; only the ack releases it.
            if (bus.out_ack) begin
               state_d  = StIdle;
               onehot_d = '0;
               valid_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pending_q <= '0;
         id_q      <= '0;
         onehot_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         id_q      <= id_d;
         onehot_q  <= onehot_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_id     = id_q;
   assign bus.out_onehot = onehot_q;
   assign bus.pending    = pending_q;

endmodule

// File: tb/tb_int_priority_encoder.sv
// Drives an MSB-priority and an LSB-priority encoder with shared stimulus and checks both
// against a behavioural model of the pending set and the handshake.
module tb_int_priority_encoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_r;
   logic       ack_r;
   logic [7:0] mask_r;

   int n_checks;
   int n_pass;

   int m_pend  [2];
   int m_valid [2];
   int m_id    [2];
   int m_oh    [2];

   int_priority_encoder_if bus0 ();
   int_priority_encoder_if bus1 ();

   assign bus0.req     = req_r;
   assign bus0.out_ack = ack_r;
   assign bus1.req     = req_r;
   assign bus1.out_ack = ack_r;
`ifdef INT_MASK_EN
   assign bus0.irq_mask = mask_r;
   assign bus1.irq_mask = mask_r;
`endif

   int_priority_encoder #(.LINES(8), .ID_W(3), .PRIO_MSB(1'b1)) u_dut_msb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   int_priority_encoder #(.LINES(8), .ID_W(3), .PRIO_MSB(1'b0)) u_dut_lsb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner as plain arithmetic on the eligible set.
   function automatic int pick(input int eff, input bit msb);
      if (msb) return $clog2(eff + 1) - 1;
      return $clog2(eff & -eff);
   endfunction

   task automatic model_edge();
      int m;
      int clr;
      int nxt;
      int eff;
      m = 0;
`ifdef INT_MASK_EN
      m = int'(mask_r);
`endif
      for (int p = 0; p < 2; p++) begin
         if (!rst_n) begin
            m_pend[p]  = 0;
            m_valid[p] = 0;
            m_id[p]    = 0;
            m_oh[p]    = 0;
         end else begin
            clr = (m_valid[p] != 0 && ack_r) ? (1 << m_id[p]) : 0;
            nxt = (m_pend[p] & ~clr) | int'(req_r);
            if (m_valid[p] == 0) begin
               eff = m_pend[p] & ~m & 8'hFF;
               if (eff != 0) begin
                  m_id[p]    = pick(eff, p == 0);
                  m_oh[p]    = 1 << m_id[p];
                  m_valid[p] = 1;
               end
            end else if (ack_r) begin
               m_valid[p] = 0;
               m_oh[p]    = 0;
            end
            m_pend[p] = nxt;
         end
      end
   endtask

   task automatic compare_all();
      check("msb_valid",  int'(bus0.out_valid),  m_valid[0]);
      check("msb_id",     int'(bus0.out_id),     m_id[0]);
      check("msb_onehot", int'(bus0.out_onehot), m_oh[0]);
      check("msb_pend",   int'(bus0.pending),    m_pend[0]);
      check("lsb_valid",  int'(bus1.out_valid),  m_valid[1]);
      check("lsb_id",     int'(bus1.out_id),     m_id[1]);
      check("lsb_onehot", int'(bus1.out_onehot), m_oh[1]);
      check("lsb_pend",   int'(bus1.pending),    m_pend[1]);
   endtask

   task automatic step(input logic r, input logic [7:0] rq, input logic a);
      rst_n = r;
      req_r = rq;
      ack_r = a;
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   // Wait (bounded) for a presentation, record both IDs, then ack it.
   task automatic serve(output int id0, output int id1);
      int n;
      n = 0;
      while (!bus0.out_valid && n < 10) begin
         step(1'b1, 8'h00, 1'b0);
         n++;
      end
      if (!bus0.out_valid) check("serve_timeout", 0, 1);
      id0 = int'(bus0.out_id);
      id1 = int'(bus1.out_id);
      step(1'b1, 8'h00, 1'b1);
      check("idle_after_ack", int'(bus0.out_valid), 0);
   endtask

   initial begin
      int a0;
      int a1;
      n_checks = 0;
      n_pass   = 0;
      mask_r   = 8'h00;
      rst_n    = 1'b0;
      req_r    = 8'hFF;
      ack_r    = 1'b0;
      for (int p = 0; p < 2; p++) begin
         m_pend[p] = 0; m_valid[p] = 0; m_id[p] = 0; m_oh[p] = 0;
      end

      // Reset dominates req; release with req still high.
      step(1'b0, 8'hFF, 1'b0);
      step(1'b0, 8'hFF, 1'b0);
      check("rst_pend", int'(bus0.pending), 0);
      check("rst_valid", int'(bus0.out_valid), 0);
      step(1'b1, 8'hFF, 1'b0);
      check("release_pend", int'(bus0.pending), 8'hFF);
      step(1'b0, 8'h00, 1'b0);

      // Single request on line 5.
      step(1'b1, 8'h20, 1'b0);
      check("single_pend_only", int'(bus0.out_valid), 0);
      step(1'b1, 8'h00, 1'b0);
      check("single_valid", int'(bus0.out_valid), 1);
      check("single_id", int'(bus0.out_id), 5);
      check("single_oh", int'(bus0.out_onehot), 8'h20);
      step(1'b1, 8'h00, 1'b1);
      check("single_pend_clr", int'(bus0.pending), 0);
      check("single_id_kept", int'(bus0.out_id), 5);

      // Priority order with 8'h85 pending.
      step(1'b1, 8'h85, 1'b0);
      serve(a0, a1);
      check("prio_msb_0", a0, 7); check("prio_lsb_0", a1, 0);
      serve(a0, a1);
      check("prio_msb_1", a0, 2); check("prio_lsb_1", a1, 2);
      serve(a0, a1);
      check("prio_msb_2", a0, 0); check("prio_lsb_2", a1, 7);

      // Hold without pre-emption, then ack with set-wins on line 3.
      step(1'b1, 8'h08, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      check("hold_first", int'(bus0.out_id), 3);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'h80, 1'b0);
         check("hold_id", int'(bus0.out_id), 3);
      end
      step(1'b1, 8'h08, 1'b1);
      check("setwin_pend", int'(bus0.pending), 8'h88);
      serve(a0, a1);
      check("setwin_next7", a0, 7); check("setwin_lsb3", a1, 3);
      serve(a0, a1);
      check("setwin_again3", a0, 3); check("setwin_lsb7", a1, 7);

      // Stray ack while idle, then reset during a presentation.
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h00, 1'b1);
      check("stray_pend", int'(bus0.pending), 8'h01);
      check("stray_present", int'(bus0.out_valid), 1);
      step(1'b0, 8'h00, 1'b0);
      check("midrst_valid", int'(bus0.out_valid), 0);
      check("midrst_pend", int'(bus0.pending), 0);

`ifdef INT_MASK_EN
      mask_r = 8'h80;
      step(1'b1, 8'h81, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      check("mask_id0", int'(bus0.out_id), 0);
      step(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h00, 1'b0);
         check("mask_blocked", int'(bus0.out_valid), 0);
      end
      mask_r = 8'h00;
      step(1'b1, 8'h00, 1'b0);
      check("unmask_valid", int'(bus0.out_valid), 1);
      check("unmask_id7", int'(bus0.out_id), 7);
      step(1'b1, 8'h00, 1'b1);
`endif

      // Randomized traffic with sparse requests and occasional reset.
      for (int i = 0; i < 400; i++) begin
`ifdef INT_MASK_EN
         mask_r = 8'($urandom & $urandom);
`endif
         step(($urandom_range(0, 49) != 0),
              8'($urandom & $urandom & $urandom),
              1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
